// File: rtl/prog_loader.sv
// prog_loader: receives a framed byte stream from the host link and writes it
// into the CPU program RAM. The CPU is held in clear for the whole load.
// A frame is COUNT, ADDR, then COUNT words sent as HI byte then LO byte.
// COUNT = 0 means 256 words.
module prog_loader (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        prog,
    output logic [7:0]  a,
    output logic [11:0] d,
    output logic        cpu_clr,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 12;
    localparam int unsigned CW = 9;

    typedef enum logic [3:0] {
        IDLE,
        GET_CNT,
        GET_ADDR,
        GET_HI,
        GET_LO,
        WRITE,
        RELEASE,
        DONE,
        ERR
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   total;      // words in this frame, 1..256
    logic [CW-1:0]   widx;       // words written so far
    logic [CW-1:0]   widx_inc;
    logic [AW-1:0]   base;
    logic [3:0]      hi_nib;
    logic            rel_cnt;
    logic            xfer_c;
    logic            nxt_get_c;
    logic            nxt_busy_c;

    // A byte is consumed only when the loader is in a receive state.
    assign xfer_c   = in_valid & in_ready;
    assign widx_inc = widx + CW'(1);

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE, ERR: begin
                if (start) state_nxt = GET_CNT;
            end
            GET_CNT: begin
                if (xfer_c) state_nxt = GET_ADDR;
            end
            GET_ADDR: begin
                if (xfer_c) state_nxt = GET_HI;
            end
            GET_HI: begin
                if (xfer_c) begin
                    if (in_data[7:4] != 4'd0) state_nxt = ERR;
                    else                      state_nxt = GET_LO;
                end
            end
            GET_LO: begin
                if (xfer_c) state_nxt = WRITE;
            end
            WRITE: begin
                if (widx_inc == total) state_nxt = RELEASE;
                else                   state_nxt = GET_HI;
            end
            RELEASE: begin
                if (rel_cnt) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode of the upcoming state, so every output is a register.
    always_comb begin
        nxt_get_c  = (state_nxt == GET_CNT) || (state_nxt == GET_ADDR) ||
                     (state_nxt == GET_HI)  || (state_nxt == GET_LO);
        nxt_busy_c = nxt_get_c || (state_nxt == WRITE) || (state_nxt == RELEASE);
    end

    // State register, registered outputs and frame datapath.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            prog     <= 1'b0;
            a        <= '0;
            d        <= '0;
            cpu_clr  <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            total    <= '0;
            widx     <= '0;
            base     <= '0;
            hi_nib   <= '0;
            rel_cnt  <= 1'b0;
        end else begin
            state    <= state_nxt;
            in_ready <= nxt_get_c;
            busy     <= nxt_busy_c;
            cpu_clr  <= (state_nxt != IDLE) && (state_nxt != DONE);
            done     <= (state_nxt == DONE);
            err      <= (state_nxt == ERR);
            // prog rises on the first WRITE and stays up across the gaps
            // between words until the final WRITE (or an abort) ends it.
            prog     <= (state_nxt == WRITE) ||
                        (prog && ((state_nxt == GET_HI) || (state_nxt == GET_LO)));

            if (state == GET_CNT && xfer_c) begin
                total <= (in_data == 8'd0) ? CW'(256) : CW'(in_data);
                widx  <= '0;
            end
            if (state == GET_ADDR && xfer_c) begin
                base <= in_data;
            end
            if (state == GET_HI && xfer_c) begin
                hi_nib <= in_data[3:0];
            end
            // Address and data move together, only on a LO byte.
            if (state == GET_LO && xfer_c) begin
                a <= AW'(base + widx[AW-1:0]);
                d <= DW'({hi_nib, in_data});
            end
            if (state == WRITE) begin
                widx <= widx_inc;
            end

            if (state == RELEASE) rel_cnt <= ~rel_cnt;
            else                  rel_cnt <= 1'b0;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a CPU-side RAM model logs every WRITE cycle.
module tb_prog_loader;

    logic        clk;
    logic        clr_n;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        prog;
    logic [7:0]  a;
    logic [11:0] d;
    logic        cpu_clr;
    logic        busy;
    logic        done;
    logic        err;

    int total;
    int bad;
    int rel_cycles;
    logic [19:0] wlog[$];
    logic [19:0] exp_q[$];
    logic [7:0]  frame_q[$];

    prog_loader dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .prog     (prog),
        .a        (a),
        .d        (d),
        .cpu_clr  (cpu_clr),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CPU side: a WRITE cycle is prog high with the loader not receiving.
    always @(negedge clk) begin
        if (clr_n && prog && !in_ready) wlog.push_back({a, d});
        if (clr_n && busy && !prog && !in_ready) rel_cycles++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte was taken.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        repeat (gap) @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            ok = in_ready;
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!ok) check("byte_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_frame(input int gmax);
        for (int i = 0; i < frame_q.size(); i++)
            send_byte(frame_q[i], (gmax > 0) ? int'($urandom_range(0, gmax)) : 0);
    endtask

    task automatic do_start();
        wlog.delete();
        rel_cycles = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            if (done || err) seen = 1'b1;
            else @(negedge clk);
        end
        if (!seen) check("end_timeout", 32'd0, 32'd1);
    endtask

    task automatic cmp_log(input string tag);
        check({tag, "_cnt"}, 32'(wlog.size()), 32'(exp_q.size()));
        if (wlog.size() == exp_q.size())
            for (int i = 0; i < exp_q.size(); i++)
                check(tag, 32'(wlog[i]), 32'(exp_q[i]));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_prog"},  32'(prog),     32'd0);
        check({tag, "_a"},     32'(a),        32'd0);
        check({tag, "_d"},     32'(d),        32'd0);
        check({tag, "_rdy"},   32'(in_ready), 32'd0);
        check({tag, "_busy"},  32'(busy),     32'd0);
        check({tag, "_done"},  32'(done),     32'd0);
        check({tag, "_err"},   32'(err),      32'd0);
        check({tag, "_clr"},   32'(cpu_clr),  32'd1);
    endtask

    initial begin
        int nb;
        logic [7:0] ea;
        total = 0; bad = 0; rel_cycles = 0;
        clr_n = 1'b0; start = 1'b0; in_data = 8'h00; in_valid = 1'b0;

        // Reset state, then cpu_clr drops on the first edge after release.
        #12;
        check_reset_outputs("rst");
        @(negedge clk);
        clr_n = 1'b1;
        @(negedge clk);
        check("idle_clr", 32'(cpu_clr), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        // Basic two-word frame.
        do_start();
        check("start_busy", 32'(busy), 32'd1);
        check("start_clr", 32'(cpu_clr), 32'd1);
        frame_q = '{8'h02, 8'h10, 8'h01, 8'h23, 8'h0F, 8'hFF};
        send_frame(0);
        wait_end();
        exp_q = '{20'h10123, 20'h11FFF};
        cmp_log("basic");
        check("basic_rel", 32'(rel_cycles), 32'd2);
        check("basic_done", 32'(done), 32'd1);
        check("basic_clr", 32'(cpu_clr), 32'd0);
        check("basic_busy", 32'(busy), 32'd0);

        // 256-word frame from F0, address wraps.
        do_start();
        frame_q.delete();
        frame_q.push_back(8'h00);
        frame_q.push_back(8'hF0);
        for (int k = 0; k < 256; k++) begin
            frame_q.push_back(8'h00);
            frame_q.push_back(8'(k));
        end
        send_frame(0);
        wait_end();
        check("wrap_cnt", 32'(wlog.size()), 32'd256);
        if (wlog.size() == 256) begin
            check("wrap_w15", 32'(wlog[15]), 32'h0FF00F);
            check("wrap_w16", 32'(wlog[16]), 32'h000010);
            check("wrap_last", 32'(wlog[255]), 32'hEF0FF);
            nb = 0;
            for (int k = 0; k < 256; k++) begin
                ea = 8'(8'hF0 + k);
                if (wlog[k] !== {ea, 12'(k)}) nb++;
            end
            check("wrap_all", 32'(nb), 32'd0);
        end
        check("wrap_done", 32'(done), 32'd1);

        // Bad HI nibble aborts before any write.
        do_start();
        check("restart_done_clr", 32'(done), 32'd0);
        frame_q = '{8'h01, 8'h05, 8'h1A};
        send_frame(0);
        check("err_flag", 32'(err), 32'd1);
        check("err_clr", 32'(cpu_clr), 32'd1);
        check("err_prog", 32'(prog), 32'd0);
        check("err_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        check("err_hold", 32'(err), 32'd1);
        check("err_nowrite", 32'(wlog.size()), 32'd0);
        do_start();
        check("err_cleared", 32'(err), 32'd0);
        // Finish this frame cleanly with one word.
        frame_q = '{8'h01, 8'h20, 8'h07, 8'h77};
        send_frame(0);
        wait_end();
        exp_q = '{20'h20777};
        cmp_log("after_err");

        // Same frame gap-free and with random valid gaps.
        frame_q = '{8'h04, 8'h30, 8'h00, 8'hA5, 8'h03, 8'hC0,
                    8'h08, 8'h00, 8'h0F, 8'hFE};
        exp_q = '{20'h300A5, 20'h313C0, 20'h32800, 20'h33FFE};
        do_start();
        send_frame(0);
        wait_end();
        cmp_log("nogap");
        do_start();
        send_frame(5);
        wait_end();
        cmp_log("gap");
        check("gap_done", 32'(done), 32'd1);

        // Reset during GET_LO of word 3 of 5.
        do_start();
        frame_q = '{8'h05, 8'h40, 8'h01, 8'h11, 8'h02, 8'h22, 8'h03};
        send_frame(0);
        in_data = 8'h33;
        in_valid = 1'b1;
        clr_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        in_valid = 1'b0;
        clr_n = 1'b1;
        repeat (4) @(negedge clk);
        exp_q = '{20'h40111, 20'h41222};
        cmp_log("midrst");
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);

        // start while busy is ignored.
        do_start();
        frame_q = '{8'h02, 8'h50};
        send_frame(0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_start_rdy", 32'(in_ready), 32'd1);
        check("busy_start_busy", 32'(busy), 32'd1);
        frame_q = '{8'h0A, 8'hBC, 8'h00, 8'h01};
        send_frame(0);
        wait_end();
        exp_q = '{20'h50ABC, 20'h51001};
        cmp_log("busy_start");
        check("busy_start_done", 32'(done), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
